// File: rtl/pipe_fetch_pkg.sv
// Shared definitions for the IF stage of the pipelined MIPS core.
// Contents:
//   PCS_*            next-PC select encodings driven by decode (pcsource)
//   fetch_state_e    instruction-memory handshake state
//   NOP_WORD         sll $0,$0,0, the word presented to decode on a bubble
//   word_align()     forces the two byte-offset bits of an address to zero
package pipe_fetch_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pipe_fetch_skid.sv
// fetch_skid: one-entry holding buffer for an instruction that returns from
// memory while decode is stalled. Stores the word and its pc+4.
// Ports:
//   clock, reset       clock and async active-high reset (clears full only)
//   load               capture in_inst/in_pc4, set full
//   clear              discard contents (redirect), wins over load/drain
//   drain              contents consumed by decode this cycle
//   in_inst, in_pc4    word and its pc+4 to capture
//   full               buffer holds a valid entry
//   inst, pc4          held entry
module fetch_skid (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        drain,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc4,
  output logic        full,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // Payload is qualified by full, so it carries no reset.
  always_ff @(posedge clock) begin
    if (load && !clear) begin
      inst <= in_inst;
      pc4  <= in_pc4;
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: IF stage. Owns the PC, fetches from a variable-latency
// instruction memory (req/ready, then in-order rvalid, at most one request
// outstanding) and drives the IF/ID register into decode.
// Ports:
//   clock, reset                  clock, async active-high reset
//   pcsource, bpc, jpc, jra       next-PC select and targets from decode
//   wpcir                         1 = advance, 0 = load-use stall
//   imem_req/addr/ready           request handshake (addr = pc)
//   imem_rvalid/rdata             returned instruction
//   pc                            current fetch PC
//   dpc4, inst, dvalid            IF/ID register
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] jra,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  fetch_state_e state_q, state_d;
  logic         accept;
  logic         redirect;
  logic         resp;
  logic [31:0]  target;
  logic         sk_full;
  logic [31:0]  sk_inst;
  logic [31:0]  sk_pc4;

  // Request is held off while reset is asserted and while a stalled word
  // sits in the skid, so no more than one instruction is ever prefetched.
  assign imem_req  = (state_q == ST_IDLE) && !sk_full && !reset;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  // Only a real instruction in ID may redirect; bubbles carry stale pcsource.
  assign redirect  = wpcir && dvalid && (pcsource != PCS_SEQ);
  assign resp      = (state_q == ST_WAIT) && imem_rvalid;

  always_comb begin
    target = pc;
    case (pcsource)
      PCS_BR:  target = word_align(bpc);
      PCS_JR:  target = word_align(jra);
      PCS_J:   target = word_align(jpc);
      default: target = pc;
    endcase
  end

  // pc already advanced on accept, so while WAITing it equals the pc+4 of
  // the outstanding request.
  fetch_skid u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (resp && !wpcir),
    .clear   (redirect),
    .drain   (wpcir && sk_full),
    .in_inst (imem_rdata),
    .in_pc4  (pc),
    .full    (sk_full),
    .inst    (sk_inst),
    .pc4     (sk_pc4)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = redirect ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        // A word arriving with a redirect is stale; it is simply not used.
        if (imem_rvalid)   state_d = ST_IDLE;
        else if (redirect) state_d = ST_DROP;
      end
      ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc      <= word_align(RESET_PC);
    end else begin
      state_q <= state_d;
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + 32'd4;
    end
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dpc4   <= 32'h0;
      inst   <= NOP_INST;
      dvalid <= 1'b0;
    end else if (redirect) begin
      inst   <= NOP_INST;
      dvalid <= 1'b0;
    end else if (wpcir) begin
      if (sk_full) begin
        inst   <= sk_inst;
        dpc4   <= sk_pc4;
        dvalid <= 1'b1;
      end else if (resp) begin
        inst   <= imem_rdata;
        dpc4   <= pc;
        dvalid <= 1'b1;
      end else begin
        inst   <= NOP_INST;
        dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
module tb_pipe_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, jra;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int total  = 0;
  int passed = 0;

  // memory model state
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic        force_en;
  logic [31:0] force_val;

  pipe_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .jra         (jra),
    .wpcir       (wpcir),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .dpc4        (dpc4),
    .inst        (inst),
    .dvalid      (dvalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h2400_0000;
  endfunction

  // One clock: samples the handshake before the edge, then plays memory.
  task automatic tick;
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req & imem_ready;
    a   = imem_addr;
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = force_en ? force_val : mdata(paddr);
        force_en    = 1'b0;
        pend        = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  endtask

  task automatic reset_on;
    reset = 1'b1;
    wpcir = 1'b1; pcsource = 2'b00;
    bpc = '0; jpc = '0; jra = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; cnt = 0; lat = 1; force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic reset_off;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset_on;
    total++; if (pc !== 32'h0)        $display("FAIL rst_pc got %h exp 0", pc); else passed++;
    total++; if (dpc4 !== 32'h0)      $display("FAIL rst_dpc4 got %h exp 0", dpc4); else passed++;
    total++; if (inst !== 32'h0)      $display("FAIL rst_inst got %h exp 0", inst); else passed++;
    total++; if (dvalid !== 1'b0)     $display("FAIL rst_dvalid got %b exp 0", dvalid); else passed++;
    total++; if (imem_req !== 1'b0)   $display("FAIL rst_req got %b exp 0", imem_req); else passed++;
    reset_off;
    #1;
    total++; if (imem_req !== 1'b1)   $display("FAIL first_req got %b exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL addr0 got %h exp 0", imem_addr); else passed++;
    tick;
    total++; if (pc !== 32'h4)        $display("FAIL pc_after_accept got %h exp 4", pc); else passed++;
    total++; if (dvalid !== 1'b0)     $display("FAIL e1_dvalid got %b exp 0", dvalid); else passed++;
    tick;
    total++; if (dpc4 !== 32'h4 || dvalid !== 1'b1 || inst !== mdata(32'h0))
      $display("FAIL seq0 got dpc4=%h v=%b inst=%h exp 4/1/%h", dpc4, dvalid, inst, mdata(32'h0)); else passed++;
    total++; if (imem_addr !== 32'h4) $display("FAIL addr4 got %h exp 4", imem_addr); else passed++;
    tick; tick;
    total++; if (dpc4 !== 32'h8 || dvalid !== 1'b1) $display("FAIL seq1 got dpc4=%h v=%b exp 8/1", dpc4, dvalid); else passed++;
    total++; if (imem_addr !== 32'h8) $display("FAIL addr8 got %h exp 8", imem_addr); else passed++;
    tick; tick;
    total++; if (dpc4 !== 32'hC || dvalid !== 1'b1 || inst !== mdata(32'h8))
      $display("FAIL seq2 got dpc4=%h v=%b inst=%h exp c/1/%h", dpc4, dvalid, inst, mdata(32'h8)); else passed++;
    // stall so a valid ID instruction is held while the next fetch is in WAIT
    wpcir = 1'b0;
    tick;
    total++; if (pc !== 32'h10 || dvalid !== 1'b1) $display("FAIL wait_hold got pc=%h v=%b exp 10/1", pc, dvalid); else passed++;
    reset = 1'b1; imem_rvalid = 1'b0;
    #1;
    total++; if (pc !== 32'h0)      $display("FAIL async_pc got %h exp 0", pc); else passed++;
    total++; if (dvalid !== 1'b0)   $display("FAIL async_dvalid got %b exp 0", dvalid); else passed++;
    total++; if (dpc4 !== 32'h0)    $display("FAIL async_dpc4 got %h exp 0", dpc4); else passed++;
    // a response arriving in IDLE after reset must be ignored
    reset_on; reset_off;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    total++; if (dvalid !== 1'b0 || pc !== 32'h4) $display("FAIL idle_rvalid got v=%b pc=%h exp 0/4", dvalid, pc); else passed++;
    tick;
    total++; if (inst !== mdata(32'h0) || dvalid !== 1'b1)
      $display("FAIL post_idle got inst=%h v=%b exp %h/1", inst, dvalid, mdata(32'h0)); else passed++;
  endtask

  task automatic test_branch;
    reset_on; reset_off;
    repeat (10) tick;
    total++; if (dpc4 !== 32'h14 || dvalid !== 1'b1) $display("FAIL br_pre got dpc4=%h v=%b exp 14/1", dpc4, dvalid); else passed++;
    pcsource = 2'b01; bpc = 32'h40;
    tick;
    pcsource = 2'b00;
    total++; if (dvalid !== 1'b0 || inst !== 32'h0) $display("FAIL br_bubble got v=%b inst=%h exp 0/0", dvalid, inst); else passed++;
    total++; if (dpc4 !== 32'h14)      $display("FAIL br_dpc4_keep got %h exp 14", dpc4); else passed++;
    total++; if (imem_addr !== 32'h40) $display("FAIL br_addr got %h exp 40", imem_addr); else passed++;
    total++; if (imem_req !== 1'b0)    $display("FAIL br_drop_req got %b exp 0", imem_req); else passed++;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || dvalid !== 1'b0)
      $display("FAIL br_refetch got req=%b addr=%h v=%b exp 1/40/0", imem_req, imem_addr, dvalid); else passed++;
    tick; tick;
    total++; if (dpc4 !== 32'h44 || dvalid !== 1'b1 || inst !== mdata(32'h40))
      $display("FAIL br_target got dpc4=%h v=%b inst=%h exp 44/1/%h", dpc4, dvalid, inst, mdata(32'h40)); else passed++;
  endtask

  task automatic test_redirect_wait;
    reset_on; reset_off;
    lat = 3;
    repeat (4) tick;
    total++; if (dpc4 !== 32'h4 || dvalid !== 1'b1) $display("FAIL rw_first got dpc4=%h v=%b exp 4/1", dpc4, dvalid); else passed++;
    wpcir = 1'b0;
    tick;
    total++; if (pc !== 32'h8 || imem_req !== 1'b0 || dvalid !== 1'b1)
      $display("FAIL rw_wait got pc=%h req=%b v=%b exp 8/0/1", pc, imem_req, dvalid); else passed++;
    wpcir = 1'b1; pcsource = 2'b11; jpc = 32'h100;
    tick;
    pcsource = 2'b00;
    total++; if (pc !== 32'h100 || dvalid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL rw_redirect got pc=%h v=%b req=%b exp 100/0/0", pc, dvalid, imem_req); else passed++;
    tick;
    total++; if (imem_req !== 1'b0) $display("FAIL rw_drop got req=%b exp 0", imem_req); else passed++;
    tick;
    total++; if (dvalid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL rw_discard got v=%b req=%b addr=%h exp 0/1/100", dvalid, imem_req, imem_addr); else passed++;
    repeat (4) tick;
    total++; if (dpc4 !== 32'h104 || dvalid !== 1'b1 || inst !== mdata(32'h100))
      $display("FAIL rw_target got dpc4=%h v=%b inst=%h exp 104/1/%h", dpc4, dvalid, inst, mdata(32'h100)); else passed++;
  endtask

  task automatic test_stall;
    reset_on; reset_off;
    tick; tick;
    force_en = 1'b1; force_val = 32'h8C01_0004;
    wpcir = 1'b0;
    tick;
    total++; if (pc !== 32'h8 || dpc4 !== 32'h4 || dvalid !== 1'b1)
      $display("FAIL st_accept got pc=%h dpc4=%h v=%b exp 8/4/1", pc, dpc4, dvalid); else passed++;
    tick;
    total++; if (imem_req !== 1'b0) $display("FAIL st_req_full got %b exp 0", imem_req); else passed++;
    total++; if (inst !== mdata(32'h0) || dpc4 !== 32'h4)
      $display("FAIL st_ifid_hold got inst=%h dpc4=%h exp %h/4", inst, dpc4, mdata(32'h0)); else passed++;
    pcsource = 2'b01; bpc = 32'h300;
    tick; tick;
    total++; if (imem_req !== 1'b0 || pc !== 32'h8)
      $display("FAIL st_hold got req=%b pc=%h exp 0/8", imem_req, pc); else passed++;
    total++; if (inst !== mdata(32'h0) || dvalid !== 1'b1)
      $display("FAIL st_ifid_hold2 got inst=%h v=%b exp %h/1", inst, dvalid, mdata(32'h0)); else passed++;
    pcsource = 2'b00; wpcir = 1'b1;
    tick;
    total++; if (inst !== 32'h8C01_0004 || dpc4 !== 32'h8 || dvalid !== 1'b1)
      $display("FAIL st_drain got inst=%h dpc4=%h v=%b exp 8c010004/8/1", inst, dpc4, dvalid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8)
      $display("FAIL st_resume got req=%b addr=%h exp 1/8", imem_req, imem_addr); else passed++;
    tick;
    total++; if (pc !== 32'hC || dvalid !== 1'b0) $display("FAIL st_next got pc=%h v=%b exp c/0", pc, dvalid); else passed++;
    tick;
    total++; if (dpc4 !== 32'hC || inst !== mdata(32'h8) || dvalid !== 1'b1)
      $display("FAIL st_after got dpc4=%h inst=%h v=%b exp c/%h/1", dpc4, inst, dvalid, mdata(32'h8)); else passed++;
  endtask

  task automatic test_jr_wrap;
    reset_on; reset_off;
    tick; tick;
    pcsource = 2'b10; jra = 32'h0000_2003;
    tick;
    pcsource = 2'b00;
    total++; if (imem_addr !== 32'h2000 || pc !== 32'h2000)
      $display("FAIL jr_addr got addr=%h pc=%h exp 2000/2000", imem_addr, pc); else passed++;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000)
      $display("FAIL jr_req got req=%b addr=%h exp 1/2000", imem_req, imem_addr); else passed++;
    tick; tick;
    total++; if (dpc4 !== 32'h2004 || dvalid !== 1'b1 || inst !== mdata(32'h2000))
      $display("FAIL jr_target got dpc4=%h v=%b inst=%h exp 2004/1/%h", dpc4, dvalid, inst, mdata(32'h2000)); else passed++;
    pcsource = 2'b11; jpc = 32'hFFFF_FFFF;
    tick;
    pcsource = 2'b00;
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL j_align got %h exp fffffffc", pc); else passed++;
    tick; tick;
    total++; if (pc !== 32'h0) $display("FAIL pc_wrap got %h exp 0", pc); else passed++;
    tick;
    total++; if (dpc4 !== 32'h0 || dvalid !== 1'b1 || inst !== mdata(32'hFFFF_FFFC))
      $display("FAIL wrap_dpc4 got dpc4=%h v=%b inst=%h exp 0/1/%h", dpc4, dvalid, inst, mdata(32'hFFFF_FFFC)); else passed++;
  endtask

  task automatic test_not_ready;
    reset_on;
    imem_ready = 1'b0;
    reset_off;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc !== 32'h0 || dvalid !== 1'b0)
        $display("FAIL nr_hold%0d got req=%b addr=%h pc=%h v=%b exp 1/0/0/0", i, imem_req, imem_addr, pc, dvalid); else passed++;
    end
    imem_ready = 1'b1;
    tick;
    total++; if (pc !== 32'h4) $display("FAIL nr_accept got pc=%h exp 4", pc); else passed++;
    tick;
    total++; if (dpc4 !== 32'h4 || dvalid !== 1'b1) $display("FAIL nr_deliver got dpc4=%h v=%b exp 4/1", dpc4, dvalid); else passed++;
  endtask

  initial begin
    test_reset;
    test_branch;
    test_redirect_wait;
    test_stall;
    test_jr_wrap;
    test_not_ready;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
- IF stage of the pipelined MIPS computer; the consumer end of the decode stage's next-PC interface (pcsource, bpc, jpc, jr target, wpcir stall).
- Owns the PC. Issues requests to a variable-latency instruction memory over a req/ready and rvalid handshake.
- Drives the IF/ID register (dpc4, inst, dvalid) into decode.
- Inserts a bubble after every taken redirect and discards in-flight stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word driven to decode on a bubble (sll $0,$0,0)

Ports:
clock      in   1   single system clock, all state on rising edge
reset      in   1   asynchronous, active-high; clears all state immediately
pcsource   in   2   from decode: 00 pc+4, 01 branch (bpc), 10 jr (jra), 11 jump (jpc)
bpc        in   32  branch target from decode
jpc        in   32  jump target from decode
jra        in   32  jr target (forwarded rs value) from decode
wpcir      in   1   1 = pipeline may advance; 0 = load-use stall, hold PC and IF/ID
imem_req   out  1   request valid; address is imem_addr
imem_addr  out  32  word-aligned fetch address (= pc)
imem_ready in   1   memory accepts request this cycle when imem_req & imem_ready
imem_rvalid in  1   returned instruction valid, one per accepted request, in order
imem_rdata in   32  returned instruction
pc         out  32  current fetch PC
dpc4       out  32  IF/ID: pc+4 of the held instruction
inst       out  32  IF/ID: instruction word
dvalid     out  1   IF/ID: 1 = real instruction, 0 = bubble (inst = NOP_INST)

Behaviour:
- Reset values: pc=RESET_PC, dpc4=0, inst=NOP_INST, dvalid=0, imem_req=0, state=IDLE, skid buffer empty.
- Reset takes effect asynchronously, including mid-request. After release, the first request is issued on the first clock edge with reset low. Responses to pre-reset requests are ignored: the state is IDLE, and rvalid in IDLE is discarded.
- At most one outstanding request.
- States:
  - IDLE: imem_req=1 unless the skid buffer is full. Accept (req & ready) -> WAIT.
  - WAIT: imem_req=0. rvalid -> deliver (see below) -> IDLE.
  - DROP: imem_req=0. rvalid -> discard -> IDLE.
- Redirect: a redirect occurs when wpcir=1 and dvalid=1 and pcsource!=00. On that edge:
  - pc <= target (01 bpc, 10 jra, 11 jpc).
  - IF/ID loads a bubble (dvalid=0, inst=NOP_INST, dpc4 unchanged).
  - Skid buffer is cleared.
  - WAIT -> DROP. If a request is accepted on the same edge, the state goes to DROP, not WAIT.
- Non-redirect advance (wpcir=1): IF/ID loads from the skid buffer if full, else from imem_rdata if rvalid in WAIT, else a bubble. pc <= pc+4 when the corresponding request was accepted. The PC increments on accept, not on return.
- Stall (wpcir=0): IF/ID, pc+4 progression beyond the held instruction, and pcsource are all ignored. An rvalid arriving in WAIT is captured into the 1-entry skid buffer (instruction + its pc+4); IF/ID is untouched.
- Skid full: imem_req=0 until drained by the next advance.
- Same-cycle stall and rvalid: the returned word goes to skid, never lost or duplicated.
- Redirect and rvalid in the same cycle in WAIT: the returned word is discarded, state -> IDLE, the new target is fetched next.
- Arithmetic: 32-bit, pc+4 wraps modulo 2^32. imem_addr[1:0] is always 00; target bits [1:0] are forced to 00.
- Throughput with 1-cycle memory: one instruction per 2 cycles (accept, return). No prefetch beyond one.

Decomposition:
- Shared package: pcsource encodings (PCS_SEQ=00, PCS_BR=01, PCS_JR=10, PCS_J=11), fetch state encoding (IDLE/WAIT/DROP), NOP word constant.
- One sub-module: fetch_skid (1-entry buffer holding inst + pc4 with full flag, load/clear/drain controls).
- PC mux and FSM stay in pipe_fetch.

Test Plan:
- Reset, then memory with ready=1 and 1-cycle rvalid: addresses 0,4,8 are issued. IF/ID shows dpc4 = 4,8,12 with dvalid=1. Assert reset mid-WAIT -> pc=0, dvalid=0 immediately.
- Branch: with a valid ID instruction at pc 0x10, drive pcsource=01, bpc=0x40, wpcir=1 -> next IF/ID is a bubble (dvalid=0, inst=0), next imem_addr=0x40, then dpc4=0x44.
- Redirect while WAIT with 3-cycle memory latency: the response for the old address is discarded (DROP). The next delivered instruction is from jpc=0x100 target, dpc4=0x104.
- Stall: wpcir=0 for 4 cycles while rvalid returns inst 0x8C01_0004 -> IF/ID unchanged, skid holds it, imem_req=0. On wpcir=1, inst=0x8C01_0004 loads and fetching resumes.
- jr: pcsource=10, jra=0x0000_2003 -> imem_addr=0x0000_2000. Also pc=0xFFFF_FFFC sequential -> next pc=0x0000_0000.
- imem_ready held 0 for 5 cycles: imem_req stays 1 with a stable address, pc does not change, and IF/ID fills with bubbles while wpcir=1.
